systolic_tile: RTL

SYSTOLIC_TILE -- requirements
Module: systolic_tile

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_pe.sv | 60 ++++++
 rtl/systolic_tile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic matrix-vector tile.
//   sa_state_e : controller states (IDLE, LOAD, COMPUTE, DRAIN)
//   sa_latency : input-accept to result latency in cycles for a ROWS x COLS array
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } sa_state_e;

  // Skew (ROWS stages counting the capture register) plus the diagonal walk
  // across COLS columns including deskew equals ROWS + COLS register stages.
  function automatic int sa_latency(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element of the weight-stationary systolic array.
//   clk, rst  : clock, synchronous active-high reset (clears every register)
//   w_we/w_in : load the stationary weight
//   a_in      : activation from the left neighbour, forwarded on a_out one cycle later
//   psum_in   : partial sum from the PE above; psum_out = psum_in + a_in * weight, registered
module sa_pe
  import sa_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic signed [IWIDTH-1:0] w_in,
  input  logic signed [IWIDTH-1:0] a_in,
  input  logic signed [OWIDTH-1:0] psum_in,
  output logic signed [IWIDTH-1:0] a_out,
  output logic signed [OWIDTH-1:0] psum_out
);

  logic signed [IWIDTH-1:0] w_q, w_d;
  logic signed [IWIDTH-1:0] a_q, a_d;
  logic signed [OWIDTH-1:0] psum_q, psum_d;

  // Full-precision signed product, sign-extended, then accumulated modulo 2^OWIDTH.
  function automatic logic signed [OWIDTH-1:0] mac(
    input logic signed [OWIDTH-1:0] acc,
    input logic signed [IWIDTH-1:0] a,
    input logic signed [IWIDTH-1:0] w
  );
    logic signed [2*IWIDTH-1:0] prod;
    logic signed [OWIDTH-1:0]   ext;
    prod = (2*IWIDTH)'(a) * (2*IWIDTH)'(w);
    ext  = OWIDTH'(prod);
    return acc + ext;
  endfunction

  always_comb begin
    w_d    = w_we ? w_in : w_q;
    a_d    = a_in;
    psum_d = mac(psum_in, a_in, w_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      a_q    <= a_d;
      psum_q <= psum_d;
    end
  end

  assign a_out    = a_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_tile.sv
// Weight-stationary ROWS x COLS systolic tile computing y = x * W.
//   clk, rst            : clock, synchronous active-high reset
//   w_valid/w_ready     : weight-row handshake, w_data = one row of W per beat
//   in_valid/in_ready   : activation handshake, in_data = one x vector
//   out_valid/out_data  : result strobe and vector (zero when not valid), no backpressure
//   busy                : high while loading weights or draining the array
// Flow: IDLE -> LOAD (ROWS beats) -> COMPUTE (stream vectors) -> w_valid -> DRAIN
// (ROWS+COLS cycles) -> LOAD for the next weight set.
module systolic_tile
  import sa_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic signed [IWIDTH-1:0] w_data [COLS],
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_data [ROWS],
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_data [COLS],
  output logic                     busy
);

  localparam int L  = sa_latency(ROWS, COLS);
  localparam int CW = $clog2(L + 1);

  if (ROWS < 2 || ROWS > 64) begin : g_rows_chk
    $error("systolic_tile: ROWS out of range 2..64");
  end
  if (COLS < 2 || COLS > 64) begin : g_cols_chk
    $error("systolic_tile: COLS out of range 2..64");
  end
  if (OWIDTH < 2*IWIDTH + $clog2(ROWS)) begin : g_owidth_chk
    $error("systolic_tile: OWIDTH too narrow for a full-precision dot product");
  end

  sa_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ROWS-1:0]   row_we;
  logic              in_accept;
  logic [L-1:0]      vld_q, vld_d;

  logic signed [IWIDTH-1:0] a_h    [ROWS][COLS+1];
  logic signed [OWIDTH-1:0] psum_v [ROWS+1][COLS];

  // Controller: cnt is the weight-row index in IDLE/LOAD and the drain timer in DRAIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          state_d = LOAD;
          cnt_d   = CW'(1);
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        in_ready = 1'b1;
        if (w_valid) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CW'(L - 1)) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    row_we = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_we[r] = w_valid && w_ready && (cnt_q == CW'(r));
    end
  end

  assign in_accept = in_valid && in_ready;
  assign vld_d     = {vld_q[L-2:0], in_accept};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q[L-1];

  // Input skew: row r passes through r+1 registers (capture + r delays);
  // idle cycles load zeros so the array carries no stale data.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [IWIDTH-1:0] sk_q [r+1];
    logic signed [IWIDTH-1:0] sk_d [r+1];

    always_comb begin
      sk_d[0] = in_accept ? in_data[r] : '0;
      for (int k = 1; k <= r; k++) begin
        sk_d[k] = sk_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          sk_q[k] <= '0;
        end
      end else begin
        sk_q <= sk_d;
      end
    end

    assign a_h[r][0] = sk_q[r];
  end

  // PE grid: activations flow right, partial sums flow down.
  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign psum_v[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(
        .IWIDTH(IWIDTH),
        .OWIDTH(OWIDTH)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .w_we     (row_we[r]),
        .w_in     (w_data[c]),
        .a_in     (a_h[r][c]),
        .psum_in  (psum_v[r][c]),
        .a_out    (a_h[r][c+1]),
        .psum_out (psum_v[r+1][c])
      );
    end
  end

  // Output deskew: column c leaves the array c cycles after column 0, so it
  // is delayed COLS-1-c cycles to line the whole vector up.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    logic signed [OWIDTH-1:0] col_res;

    if (D == 0) begin : g_direct
      assign col_res = psum_v[ROWS][c];
    end else begin : g_delay
      logic signed [OWIDTH-1:0] dq_q [D];
      logic signed [OWIDTH-1:0] dq_d [D];

      always_comb begin
        dq_d[0] = psum_v[ROWS][c];
        for (int k = 1; k < D; k++) begin
          dq_d[k] = dq_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            dq_q[k] <= '0;
          end
        end else begin
          dq_q <= dq_d;
        end
      end

      assign col_res = dq_q[D-1];
    end

    assign out_data[c] = out_valid ? col_res : '0;
  end

endmodule
